// File: rtl/mc_pkg.sv
// Shared types and constants for the missionary/cannibal move checker.
package mc_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE, ERROR} state_t;

    typedef enum logic [2:0] {
        NONE      = 3'd0,
        BAD_START = 3'd1,
        BAD_DIR   = 3'd2,
        BAD_LOAD  = 3'd3,
        UNSAFE    = 3'd4,
        TIMEOUT   = 3'd5,
        LOOP      = 3'd6
    } err_t;

    localparam logic [1:0] MC_TOTAL = 2'd3;

    // Missionaries are eaten when present and outnumbered on the same bank.
    function automatic logic bank_unsafe(input logic [1:0] m, input logic [1:0] c);
        return (m != 2'd0) && (c > m);
    endfunction

endpackage

// File: rtl/mc_legal_check.sv
// Combinational legality check of one move against the previous start-bank counts.
module mc_legal_check
    import mc_pkg::*;
(
    input  logic [1:0] prev_m,
    input  logic [1:0] prev_c,
    input  logic [1:0] m,
    input  logic [1:0] c,
    input  logic       side,
    output logic [2:0] code
);

    logic       dir_ok;
    logic [1:0] abs_dm;
    logic [1:0] abs_dc;
    logic [2:0] load;
    logic       unsafe;

    assign dir_ok = side ? ((m >= prev_m) && (c >= prev_c))
                         : ((m <= prev_m) && (c <= prev_c));
    assign abs_dm = (prev_m >= m) ? prev_m - m : m - prev_m;
    assign abs_dc = (prev_c >= c) ? prev_c - c : c - prev_c;
    assign load   = {1'b0, abs_dm} + {1'b0, abs_dc};
    assign unsafe = bank_unsafe(m, c) || bank_unsafe(MC_TOTAL - m, MC_TOTAL - c);

    // Lowest code wins when several causes apply.
    always_comb begin
        code = NONE;
        if (!dir_ok)
            code = BAD_DIR;
        else if ((load == 3'd0) || (load > 3'd2))
            code = BAD_LOAD;
        else if (unsafe)
            code = UNSAFE;
    end

endmodule

// File: rtl/mc_move_checker.sv
// Move-sequence checker for the missionary/cannibal solver stream.
// Optional repeated-state detection is built when MC_LOOP_DETECT_EN is defined.
module mc_move_checker
    import mc_pkg::*;
#(
    parameter int unsigned MOVE_W    = 4,
    parameter int unsigned MAX_MOVES = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        missionary_in,
    input  logic [1:0]        cannibal_in,
    output logic              boat_side,
    output logic [MOVE_W-1:0] move_count,
    output logic              done,
    output logic              error,
    output logic [2:0]        err_code
);

    state_t     state;
    logic [1:0] prev_m;
    logic [1:0] prev_c;
    logic [2:0] check_code;
    logic       accept;
    logic       final_move;
    logic       timeout_hit;
    logic [MOVE_W-1:0] count_next;

    assign accept      = in_valid && in_ready;
    assign final_move  = (missionary_in == 2'd0) && (cannibal_in == 2'd0) && !boat_side;
    assign timeout_hit = (move_count == MOVE_W'(MAX_MOVES - 1));
    assign count_next  = (move_count == MOVE_W'(MAX_MOVES)) ? move_count : move_count + 1'b1;

`ifdef MC_LOOP_DETECT_EN
    logic [31:0] visited;
    logic [4:0]  visit_idx;
    assign visit_idx = {~boat_side, missionary_in, cannibal_in};
`endif

    mc_legal_check u_legal (
        .prev_m (prev_m),
        .prev_c (prev_c),
        .m      (missionary_in),
        .c      (cannibal_in),
        .side   (boat_side),
        .code   (check_code)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            state      <= IDLE;
            prev_m     <= '0;
            prev_c     <= '0;
            boat_side  <= 1'b0;
            move_count <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= NONE;
            in_ready   <= 1'b1;
`ifdef MC_LOOP_DETECT_EN
            visited    <= '0;
`endif
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if ((missionary_in == MC_TOTAL) && (cannibal_in == MC_TOTAL)) begin
                        state     <= RUN;
                        prev_m    <= MC_TOTAL;
                        prev_c    <= MC_TOTAL;
                        boat_side <= 1'b0;
`ifdef MC_LOOP_DETECT_EN
                        visited   <= 32'd1 << {1'b0, MC_TOTAL, MC_TOTAL};
`endif
                    end else begin
                        state    <= ERROR;
                        error    <= 1'b1;
                        err_code <= BAD_START;
                        in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    if (check_code != NONE) begin
                        state    <= ERROR;
                        error    <= 1'b1;
                        err_code <= check_code;
                        in_ready <= 1'b0;
                    end else if (final_move) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        prev_m     <= missionary_in;
                        prev_c     <= cannibal_in;
                        boat_side  <= 1'b1;
                        move_count <= count_next;
                        in_ready   <= 1'b0;
                    end else if (timeout_hit) begin
                        // The move itself was legal, so it is counted before freezing.
                        state      <= ERROR;
                        error      <= 1'b1;
                        err_code   <= TIMEOUT;
                        move_count <= count_next;
                        in_ready   <= 1'b0;
`ifdef MC_LOOP_DETECT_EN
                    end else if (visited[visit_idx]) begin
                        state    <= ERROR;
                        error    <= 1'b1;
                        err_code <= LOOP;
                        in_ready <= 1'b0;
`endif
                    end else begin
                        prev_m     <= missionary_in;
                        prev_c     <= cannibal_in;
                        boat_side  <= ~boat_side;
                        move_count <= count_next;
`ifdef MC_LOOP_DETECT_EN
                        visited[visit_idx] <= 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
